// File: rtl/vga_pkg.sv
// Shared VGA plot-path definitions.
//   - Default screen geometry and field widths for the 160x120 frame.
//   - Colour-source mode encodings for the rectangle engine.
//   - FSM state encoding of the rectangle engine (plain 2-bit constants).
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 9;

  localparam logic MODE_RESTORE = 1'b0;
  localparam logic MODE_FILL    = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/vga_addr_calc.sv
// Combinational (x, y) -> linear frame RAM address translator.
//   x    : column
//   y    : row
//   addr : y * SCREEN_W + x
module vga_addr_calc #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int X_W      = vga_pkg::X_W,
  parameter int Y_W      = vga_pkg::Y_W,
  parameter int ADDR_W   = vga_pkg::ADDR_W
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  assign addr = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);

endmodule

// File: rtl/rect_restore_engine.sv
// Rectangle redraw engine: walks a clipped rectangle in raster order and
// emits one plotted pixel per cycle, coloured from a background frame RAM
// (restore) or a constant (fill).
//   clk, resetn          : clock, synchronous active-low reset
//   start, mode          : job request (sampled in IDLE), colour source
//   x0, y0, w, h         : rectangle origin and size (clipped to the screen)
//   fill_colour          : colour used in fill mode
//   ram_addr, ram_data   : frame RAM read port, RAM_LATENCY cycles deep
//   busy, done           : job in progress, one-cycle completion pulse
//   plot, x, y, colour   : VGA adapter write port
module rect_restore_engine
  import vga_pkg::*;
#(
  parameter int SCREEN_W    = vga_pkg::SCREEN_W,
  parameter int SCREEN_H    = vga_pkg::SCREEN_H,
  parameter int X_W         = vga_pkg::X_W,
  parameter int Y_W         = vga_pkg::Y_W,
  parameter int ADDR_W      = vga_pkg::ADDR_W,
  parameter int COLOUR_W    = vga_pkg::COLOUR_W,
  parameter int RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [COLOUR_W-1:0] ram_data,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  // Clipping arithmetic is one bit wider than the fields so x0 >= SCREEN_W
  // and the subtraction never wrap.
  localparam logic [X_W:0] SW    = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH    = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] ONE_X = (X_W+1)'(1);
  localparam logic [Y_W:0] ONE_Y = (Y_W+1)'(1);
  // Only the output stage still valid: the last pixel is plotting now.
  localparam logic [RAM_LATENCY-1:0] LAST_ONLY = (RAM_LATENCY)'(1) << (RAM_LATENCY-1);

  logic [1:0]          state, state_nx;
  logic [X_W-1:0]      cx, cx_nx, x_lo, x_hi;
  logic [Y_W-1:0]      cy, cy_nx, y_hi;
  logic                mode_q;
  logic [COLOUR_W-1:0] fill_q, colour_q, colour_live;
  logic [X_W:0]        cw, x_end;
  logic [Y_W:0]        ch, y_end;
  logic                empty, adv, issue_v;
  logic [ADDR_W-1:0]   addr_nx;

  // Address-side pipeline: valid bits plus the coordinates of each in-flight
  // pixel; the last stage lines up with ram_data.
  logic [RAM_LATENCY-1:0] pipe_v;
  logic [RAM_LATENCY:0]   pipe_v_shift;
  logic [X_W-1:0]         px [RAM_LATENCY];
  logic [Y_W-1:0]         py [RAM_LATENCY];

  // Clip against the screen edges.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    cw = '0;
    ch = '0;
    if ({1'b0, x0} < SW) begin
      cw = SW - {1'b0, x0};
      if ({1'b0, w} < cw) cw = {1'b0, w};
    end
    if ({1'b0, y0} < SH) begin
      ch = SH - {1'b0, y0};
      if ({1'b0, h} < ch) ch = {1'b0, h};
    end
    empty = (cw == '0) || (ch == '0);
    x_end = {1'b0, x0} + cw - ONE_X;
    y_end = {1'b0, y0} + ch - ONE_Y;
  end

  // Next-state and address-counter logic.
  always_comb begin
    state_nx = state;
    cx_nx    = cx;
    cy_nx    = cy;
    adv      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cx_nx = x0;
          cy_nx = y0;
          if (empty) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_ISSUE;
            adv      = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cx == x_hi) begin
          cx_nx = x_lo;
          if (cy == y_hi) begin
            state_nx = ST_DRAIN;
          end else begin
            cy_nx = cy + 1'b1;
            adv   = 1'b1;
          end
        end else begin
          cx_nx = cx + 1'b1;
          adv   = 1'b1;
        end
      end
      ST_DRAIN: if (pipe_v == LAST_ONLY) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  vga_addr_calc #(
    .SCREEN_W(SCREEN_W),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_calc (
    .x   (cx_nx),
    .y   (cy_nx),
    .addr(addr_nx)
  );

  assign issue_v      = (state == ST_ISSUE);
  assign pipe_v_shift = {pipe_v, issue_v};
  assign colour_live  = (mode_q == MODE_FILL) ? fill_q : ram_data;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state    <= ST_IDLE;
      cx       <= '0;
      cy       <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
      mode_q   <= MODE_RESTORE;
      fill_q   <= '0;
      ram_addr <= '0;
      colour_q <= '0;
      pipe_v   <= '0;
      // NOTE: the coordinate pipeline is reset too because its last stage drives x/y, which must read 0 out of reset.
      for (int i = 0; i < RAM_LATENCY; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        x_lo   <= x0;
        x_hi   <= x_end[X_W-1:0];
        y_hi   <= y_end[Y_W-1:0];
        mode_q <= mode;
        fill_q <= fill_colour;
      end
      if (adv) begin
        cx       <= cx_nx;
        cy       <= cy_nx;
        ram_addr <= addr_nx;
      end
      // Valid always shifts; coordinates move only with a valid pixel so the
      // output stage holds the last plotted position.
      pipe_v <= pipe_v_shift[RAM_LATENCY-1:0];
      if (issue_v) begin
        px[0] <= cx;
        py[0] <= cy;
      end
      for (int i = 1; i < RAM_LATENCY; i++) begin
        if (pipe_v[i-1]) begin
          px[i] <= px[i-1];
          py[i] <= py[i-1];
        end
      end
      if (plot) colour_q <= colour_live;
    end
  end

  assign plot   = pipe_v[RAM_LATENCY-1];
  assign x      = px[RAM_LATENCY-1];
  assign y      = py[RAM_LATENCY-1];
  assign colour = plot ? colour_live : colour_q;
  assign busy   = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_rect_restore_engine.sv
// Directed bench for rect_restore_engine: one instance with RAM_LATENCY=1
// and one with RAM_LATENCY=3, each fed by a behavioural frame RAM holding
// mem[a] = a[8:0]. Cycle numbers are relative to the start-accept edge k.
module tb_rect_restore_engine;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } plot_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] x0 = '0, w = '0;
  logic [6:0] y0 = '0, h = '0;
  logic [8:0] fill_colour = '0;

  logic [14:0] addr1, addr3;
  logic [8:0]  rd1, rd3, r3a, r3b;
  logic        busy1, done1, plot1, busy3, done3, plot3;
  logic [7:0]  xo1, xo3;
  logic [6:0]  yo1, yo3;
  logic [8:0]  col1, col3;
  bit          zero_ram = 1'b0;

  int ecnt = 0;
  int k1 = 0, k3 = 0;
  int n_cmp = 0, n_bad = 0;
  plot_t q1[$], q3[$];
  int dn1[$], dn3[$];

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Frame RAM models: latency 1 and latency 3.
  always @(posedge clk) rd1 <= zero_ram ? 9'd0 : addr1[8:0];
  always @(posedge clk) begin
    r3a <= addr3[8:0];
    r3b <= r3a;
    rd3 <= r3b;
  end

  rect_restore_engine #(.RAM_LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .mode(mode), .x0(x0), .y0(y0),
    .w(w), .h(h), .fill_colour(fill_colour), .ram_addr(addr1), .ram_data(rd1),
    .busy(busy1), .done(done1), .plot(plot1), .x(xo1), .y(yo1), .colour(col1)
  );

  rect_restore_engine #(.RAM_LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .mode(mode), .x0(x0), .y0(y0),
    .w(w), .h(h), .fill_colour(fill_colour), .ram_addr(addr3), .ram_data(rd3),
    .busy(busy3), .done(done3), .plot(plot3), .x(xo3), .y(yo3), .colour(col3)
  );

  // Record every plot and done with its cycle number relative to k.
  always @(negedge clk) begin
    if (plot1) q1.push_back('{ecnt - k1 + 1, int'(xo1), int'(yo1), int'(col1)});
    if (done1) dn1.push_back(ecnt - k1 + 1);
    if (plot3) q3.push_back('{ecnt - k3 + 1, int'(xo3), int'(yo3), int'(col3)});
    if (done3) dn3.push_back(ecnt - k3 + 1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Accepts a job on the chosen instance; returns during cycle k+1.
  task automatic run_start(input bit sel, input int ax, input int ay, input int aw,
                           input int ah, input bit amode, input int afc);
    @(negedge clk);
    x0 = 8'(ax); y0 = 7'(ay); w = 8'(aw); h = 7'(ah);
    mode = amode; fill_colour = 9'(afc);
    if (sel) begin
      q3.delete(); dn3.delete(); start3 = 1'b1;
    end else begin
      q1.delete(); dn1.delete(); start1 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (sel) k3 = ecnt; else k1 = ecnt;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? dn3.size() : dn1.size()) != 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Counts deviations of a recorded plot stream from the raster-order model.
  function automatic int verify(input bit sel, input int vx0, input int vy0, input int cw,
                                input int ch, input int lat, input bit fill, input int fcol);
    int bad = 0;
    int sz;
    int ex, ey, ecol;
    plot_t r;
    sz = sel ? q3.size() : q1.size();
    if (sz != cw * ch) bad++;
    for (int n = 0; n < sz && n < cw * ch; n++) begin
      if (sel) r = q3[n]; else r = q1[n];
      ex   = vx0 + n % cw;
      ey   = vy0 + n / cw;
      ecol = fill ? fcol : (ey * 160 + ex) % 512;
      if (r.cyc != 1 + n + lat || r.x != ex || r.y != ey || r.col != ecol) bad++;
    end
    return bad;
  endfunction

  initial begin
    int n_at;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_plot", plot1, 0);
    check("rst_x", xo1, 0);
    check("rst_y", yo1, 0);
    check("rst_colour", col1, 0);
    check("rst_addr", addr1, 0);
    check("rst_plot3", plot3, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Restore 80x40 at (39,39), latency 1.
    run_start(0, 39, 39, 80, 40, 1'b0, 0);
    check("t1_busy", busy1, 1);
    wait_done(0, 4000);
    check("t1_count", q1.size(), 3200);
    if (q1.size() == 3200) begin
      check("t1_first_cyc", q1[0].cyc, 2);
      check("t1_first_x", q1[0].x, 39);
      check("t1_first_y", q1[0].y, 39);
      check("t1_first_col", q1[0].col, 135);
      check("t1_p80_x", q1[80].x, 39);
      check("t1_p80_y", q1[80].y, 40);
      check("t1_last_x", q1[3199].x, 118);
      check("t1_last_y", q1[3199].y, 78);
      check("t1_last_cyc", q1[3199].cyc, 3201);
      check("t1_last_col", q1[3199].col, 310);
    end
    check("t1_stream", verify(0, 39, 39, 80, 40, 1, 1'b0, 0), 0);
    check("t1_done_n", dn1.size(), 1);
    if (dn1.size() > 0) check("t1_done_cyc", dn1[0], 3202);

    // Clip at the bottom-right corner: 10x5 remain.
    run_start(0, 150, 115, 20, 10, 1'b0, 0);
    wait_done(0, 200);
    check("t2_count", q1.size(), 50);
    if (q1.size() == 50) begin
      check("t2_first_x", q1[0].x, 150);
      check("t2_first_col", q1[0].col, 118);
      check("t2_last_x", q1[49].x, 159);
      check("t2_last_y", q1[49].y, 119);
      check("t2_last_col", q1[49].col, 255);
    end
    check("t2_stream", verify(0, 150, 115, 10, 5, 1, 1'b0, 0), 0);
    if (dn1.size() > 0) check("t2_done_cyc", dn1[0], 52);

    // Fully off-screen in x, then in y: zero plots, done in cycle 1.
    run_start(0, 160, 10, 5, 5, 1'b0, 0);
    check("t2b_busy", busy1, 0);
    check("t2b_done_now", done1, 1);
    wait_done(0, 20);
    check("t2b_count", q1.size(), 0);
    if (dn1.size() > 0) check("t2b_done_cyc", dn1[0], 1);
    run_start(0, 5, 120, 5, 3, 1'b0, 0);
    wait_done(0, 20);
    check("t2c_count", q1.size(), 0);
    if (dn1.size() > 0) check("t2c_done_cyc", dn1[0], 1);

    // Fill mode with RAM data forced to zero.
    zero_ram = 1'b1;
    run_start(0, 0, 0, 2, 2, 1'b1, 9'h1FF);
    wait_done(0, 50);
    zero_ram = 1'b0;
    check("t3_stream", verify(0, 0, 0, 2, 2, 1, 1'b1, 9'h1FF), 0);
    if (q1.size() == 4) begin
      check("t3_p1_x", q1[1].x, 1);
      check("t3_p2_y", q1[2].y, 1);
      check("t3_p3_col", q1[3].col, 9'h1FF);
    end

    // Latency 3: 4x1 at (10,5).
    run_start(1, 10, 5, 4, 1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_addr_c%0d", i + 1), addr3, 810 + i);
      @(posedge clk);
      #1;
    end
    wait_done(1, 50);
    check("t4_stream", verify(1, 10, 5, 4, 1, 3, 1'b0, 0), 0);
    if (q3.size() == 4) check("t4_first_cyc", q3[0].cyc, 4);
    if (dn3.size() > 0) check("t4_done_cyc", dn3[0], 8);
    check("t4_hold_addr", addr3, 813);
    check("t4_hold_x", xo3, 13);
    check("t4_hold_y", yo3, 5);
    check("t4_hold_col", col3, 301);

    // Start reasserted with a different origin while busy: ignored.
    run_start(0, 20, 20, 10, 2, 1'b0, 0);
    repeat (5) @(negedge clk);
    x0 = 8'd0;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    start1 = 1'b0;
    wait_done(0, 100);
    repeat (30) @(negedge clk);
    check("t5_stream", verify(0, 20, 20, 10, 2, 1, 1'b0, 0), 0);
    check("t5_done_n", dn1.size(), 1);

    // Reset at pixel 100 of an 80x40 job, then a fresh job.
    run_start(0, 39, 39, 80, 40, 1'b0, 0);
    for (int i = 0; i < 300 && q1.size() < 100; i++) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_plot", plot1, 0);
    check("t6_busy", busy1, 0);
    n_at = q1.size();
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_no_more_plots", q1.size(), n_at);
    check("t6_no_done", dn1.size(), 0);
    run_start(0, 2, 2, 5, 3, 1'b0, 0);
    wait_done(0, 100);
    check("t6_new_stream", verify(0, 2, 2, 5, 3, 1, 1'b0, 0), 0);
    if (dn1.size() > 0) check("t6_new_done_cyc", dn1[0], 17);
    check("t6_new_done_n", dn1.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
